csr_mem: RTL and testbench
==========================

CSR_MEM -- requirements
Module: csr_mem

Interface
REQ-001 Parameter DATA_SIZE, default 64, bus data width; legal values 32 and 64.
REQ-002 Parameter CLOCK_CYCLES, default 30, clock cycles per mtime increment; minimum 2.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wb_if_s  wishbone secondary modport, members listed in REQ-006..REQ-013.
REQ-006 cyc  input  1  bus cycle valid.
REQ-007 stb  input  1  strobe.
REQ-008 we  input  1  1 = write, 0 = read.
REQ-009 addr  input  3  register select; addr[1:0] selects register, addr[2] selects upper word in 32-bit mode.
REQ-010 dat_o_p (primary to secondary)  input  DATA_SIZE  write data.
REQ-011 dat_i_p (secondary to primary)  output  DATA_SIZE  read data.
REQ-012 ack  output  1  transfer acknowledge.
REQ-013 sel, tgd  input  ignored.
REQ-014 msip  output  DATA_SIZE  software-interrupt register.
REQ-015 mtime  output  64  timer counter.
REQ-016 mtimecmp  output  64  timer compare register.

Function
REQ-017 Register map on addr[1:0]: 2'b00 msip, 2'b10 mtime, 2'b11 mtimecmp, 2'b01 unmapped.
REQ-018 A request is accepted on a rising edge where cyc=1, stb=1, and no transfer is in flight.
REQ-019 A transfer is in flight while the internal accept flag or ack is high.
REQ-020 Writes take effect on the accepting edge.
REQ-021 Internal accept flag sets on the accepting edge; ack goes 1 on the following edge and stays 1 for exactly one cycle.
REQ-022 ack is asserted regardless of whether stb is still high; it is asserted for unmapped addresses too.
REQ-023 dat_i_p is combinational from addr and the current register contents, so the read value reflects any update on the ack edge.
REQ-024 64-bit mode: msip, mtime and mtimecmp are full-word read/write; addr[2] is ignored.
REQ-025 32-bit mode: mtime/mtimecmp access the upper word when addr[2]=1 and the lower word when addr[2]=0.
REQ-026 32-bit mode, write: the other half of the 64-bit register is unchanged.
REQ-027 32-bit mode, read: the selected half is returned.
REQ-028 msip stores all DATA_SIZE bits written.
REQ-029 Unmapped address: writes are ignored; reads return 0.
REQ-030 Prescaler: a free-running counter 0..CLOCK_CYCLES-1 wraps to 0; it is never affected by bus writes.
REQ-031 tick is high while the prescaler equals CLOCK_CYCLES-1.
REQ-032 On each edge with tick=1, mtime increments by 1 (64-bit, wraps from all-ones to 0).
REQ-033 When an mtime write and a tick share an edge, the written value is loaded and that tick's increment is dropped.
REQ-034 mtimecmp changes only by bus write.
REQ-035 msip, mtime and mtimecmp outputs are the live register values.

Reset
REQ-036 While reset=0: msip=0, mtime=0, mtimecmp=0, prescaler=0, accept flag=0, ack=0.
REQ-037 Reset asserted mid-transfer aborts the transfer and no ack is issued; pending write effects already applied remain cleared by reset.
REQ-038 After reset release, the first tick occurs CLOCK_CYCLES-1 edges later; mtime=1 after CLOCK_CYCLES edges.

Verification
REQ-039 Reset, no bus traffic -> all outputs 0; mtime=1 after 30 edges and 2 after 60 edges (CLOCK_CYCLES=30).
REQ-040 64-bit write msip=0x0123456789ABCDEF, stb dropped after 1 cycle -> ack=1 on 2nd edge, msip and dat_i_p = 0x0123456789ABCDEF.
REQ-041 64-bit write mtime=0x100 on the edge before a tick -> mtime=0x101 when ack is seen.
REQ-042 64-bit write mtime=0x100 with no tick -> mtime=0x100 and dat_i_p=0x100 at ack.
REQ-043 32-bit: write mtimecmp addr=3'b111 data 0xAAAA5555, then addr=3'b011 data 0x12345678 -> mtimecmp=0xAAAA555512345678; read addr=3'b111 returns 0xAAAA5555.
REQ-044 Write to addr 3'b001 -> ack=1, no register changes; a read of the same address returns 0.

Source files
------------

// File: rtl/csr_mem_if.sv
// Wishbone-style register bus between a primary and the CSR block.
// Latency: none, this is wiring only.
// Backpressure: the primary holds cyc/stb until the slave returns ack.
interface csr_mem_if #(
    parameter int DATA_SIZE = 64
);
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [2:0]             addr;
    logic [DATA_SIZE-1:0]   dat_o_p;
    logic [DATA_SIZE-1:0]   dat_i_p;
    logic                   ack;
    logic [DATA_SIZE/8-1:0] sel;
    logic                   tgd;

    modport master (
        output cyc, stb, we, addr, dat_o_p, sel, tgd,
        input  dat_i_p, ack
    );

    modport slave (
        input  cyc, stb, we, addr, dat_o_p, sel, tgd,
        output dat_i_p, ack
    );
endinterface

// File: rtl/csr_mem.sv
// Machine timer / software-interrupt CSR block (msip, mtime, mtimecmp).
// Latency: a write lands on the accepting edge; ack follows one edge later, for one cycle.
// Backpressure: a new request is accepted only when no transfer is in flight.
module csr_mem #(
    parameter int DATA_SIZE    = 64,
    parameter int CLOCK_CYCLES = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    csr_mem_if.slave             wb_if_s,
    output logic [DATA_SIZE-1:0] msip,
    output logic [63:0]          mtime,
    output logic [63:0]          mtimecmp
);
    localparam int            PW      = $clog2(CLOCK_CYCLES);
    localparam logic [PW-1:0] PS_LAST = PW'(CLOCK_CYCLES - 1);

    // Bus transfer states: ST_HOLD is the accept flag, ST_ACK drives ack.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ACK  = 2'd2
    } bus_st_t;

    bus_st_t              state_q;
    bus_st_t              state_d;
    logic                 accept;
    logic                 wr;
    logic                 wr_msip;
    logic                 wr_mtime;
    logic                 wr_cmp;
    logic                 tick;
    logic [PW-1:0]        presc_q;
    logic [DATA_SIZE-1:0] msip_q;
    logic [63:0]          mtime_q;
    logic [63:0]          cmp_q;
    logic [63:0]          mtime_wr;
    logic [63:0]          cmp_wr;
    logic [DATA_SIZE-1:0] mtime_rd;
    logic [DATA_SIZE-1:0] cmp_rd;
    logic [DATA_SIZE-1:0] rd_dat;

    // Transfer state register; reset aborts any transfer in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept only from idle; ack does not wait on stb staying high.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_if_s.cyc && wb_if_s.stb) begin
                    accept  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign wb_if_s.ack = (state_q == ST_ACK);

    assign wr       = accept && wb_if_s.we;
    assign wr_msip  = wr && (wb_if_s.addr[1:0] == 2'b00);
    assign wr_mtime = wr && (wb_if_s.addr[1:0] == 2'b10);
    assign wr_cmp   = wr && (wb_if_s.addr[1:0] == 2'b11);

    // Word-size dependent write merge and read selection for the 64-bit registers.
    if (DATA_SIZE == 64) begin : g_full
        assign mtime_wr = wb_if_s.dat_o_p;
        assign cmp_wr   = wb_if_s.dat_o_p;
        assign mtime_rd = mtime_q;
        assign cmp_rd   = cmp_q;
    end else begin : g_half
        // addr[2] picks the half; the other half keeps its current value.
        assign mtime_wr = wb_if_s.addr[2] ? {wb_if_s.dat_o_p, mtime_q[31:0]}
                                          : {mtime_q[63:32], wb_if_s.dat_o_p};
        assign cmp_wr   = wb_if_s.addr[2] ? {wb_if_s.dat_o_p, cmp_q[31:0]}
                                          : {cmp_q[63:32], wb_if_s.dat_o_p};
        assign mtime_rd = wb_if_s.addr[2] ? mtime_q[63:32] : mtime_q[31:0];
        assign cmp_rd   = wb_if_s.addr[2] ? cmp_q[63:32]   : cmp_q[31:0];
    end

    // Free-running prescaler, untouched by the bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (presc_q == PS_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick = (presc_q == PS_LAST);

    // mtime: a bus write wins over the tick on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime_q <= '0;
        end else if (wr_mtime) begin
            mtime_q <= mtime_wr;
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    // msip and mtimecmp change only through bus writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msip_q <= '0;
            cmp_q  <= '0;
        end else begin
            if (wr_msip) begin
                msip_q <= wb_if_s.dat_o_p;
            end
            if (wr_cmp) begin
                cmp_q <= cmp_wr;
            end
        end
    end

    // Read data is combinational so the ack cycle sees the latest contents.
    always_comb begin
        rd_dat = '0;
        case (wb_if_s.addr[1:0])
            2'b00:   rd_dat = msip_q;
            2'b10:   rd_dat = mtime_rd;
            2'b11:   rd_dat = cmp_rd;
            default: rd_dat = '0;
        endcase
    end

    assign wb_if_s.dat_i_p = rd_dat;
    assign msip            = msip_q;
    assign mtime           = mtime_q;
    assign mtimecmp        = cmp_q;
endmodule

// File: tb/tb_csr_mem.sv
// Directed bench for csr_mem in 64-bit and 32-bit bus modes.
// Latency: checks ack one edge after accept and timer ticks every 30 edges.
// Backpressure: checks that held requests are not re-accepted while in flight.
module tb_csr_mem;
    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;
    int   edge_n;

    logic [63:0] msip64;
    logic [63:0] mtime64;
    logic [63:0] cmp64;
    logic [31:0] msip32;
    logic [63:0] mtime32;
    logic [63:0] cmp32;

    localparam logic [63:0] D_MSIP = 64'h0123456789ABCDEF;
    localparam logic [63:0] D_CMP  = 64'hFEDCBA9876543210;

    csr_mem_if #(.DATA_SIZE(64)) bus64 ();
    csr_mem_if #(.DATA_SIZE(32)) bus32 ();

    csr_mem #(.DATA_SIZE(64), .CLOCK_CYCLES(30)) u64 (
        .clock    (clock),
        .reset    (reset),
        .wb_if_s  (bus64.slave),
        .msip     (msip64),
        .mtime    (mtime64),
        .mtimecmp (cmp64)
    );

    csr_mem #(.DATA_SIZE(32), .CLOCK_CYCLES(30)) u32 (
        .clock    (clock),
        .reset    (reset),
        .wb_if_s  (bus32.slave),
        .msip     (msip32),
        .mtime    (mtime32),
        .mtimecmp (cmp32)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling or driving.
    task automatic step();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    task automatic set64(input logic c, input logic s, input logic w,
                         input logic [2:0] a, input logic [63:0] d);
        bus64.cyc     = c;
        bus64.stb     = s;
        bus64.we      = w;
        bus64.addr    = a;
        bus64.dat_o_p = d;
    endtask

    task automatic set32(input logic c, input logic s, input logic w,
                         input logic [2:0] a, input logic [31:0] d);
        bus32.cyc     = c;
        bus32.stb     = s;
        bus32.we      = w;
        bus32.addr    = a;
        bus32.dat_o_p = d;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        edge_n  = 0;
        bus64.sel = '0;
        bus64.tgd = 1'b0;
        bus32.sel = '0;
        bus32.tgd = 1'b0;
        set64(1'b0, 1'b0, 1'b0, 3'b000, 64'd0);
        set32(1'b0, 1'b0, 1'b0, 3'b000, 32'd0);
        reset = 1'b1;
        #1 reset = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_msip64", msip64, 64'd0);
        chk("rst_mtime64", mtime64, 64'd0);
        chk("rst_cmp64", cmp64, 64'd0);
        chk("rst_ack64", 64'(bus64.ack), 64'd0);
        chk("rst_msip32", 64'(msip32), 64'd0);
        chk("rst_mtime32", mtime32, 64'd0);
        chk("rst_ack32", 64'(bus32.ack), 64'd0);

        // Release between edges; count edges from here
        reset  = 1'b1;
        edge_n = 0;

        // Timer: first tick on edge 30, second on edge 60
        repeat (29) step();
        chk("mtime_e29", mtime64, 64'd0);
        step();
        chk("mtime_e30", mtime64, 64'd1);
        repeat (29) step();
        chk("mtime_e59", mtime64, 64'd1);
        step();
        chk("mtime_e60", mtime64, 64'd2);
        chk("mtime32_e60", mtime32, 64'd2);

        // msip write, stb dropped after the accepting edge
        set64(1'b1, 1'b1, 1'b1, 3'b000, D_MSIP);
        step();                                   // edge 61: accept
        chk("msip_ack_early", 64'(bus64.ack), 64'd0);
        set64(1'b1, 1'b0, 1'b1, 3'b000, D_MSIP);
        step();                                   // edge 62: ack
        chk("msip_ack", 64'(bus64.ack), 64'd1);
        chk("msip_val", msip64, D_MSIP);
        chk("msip_rd", bus64.dat_i_p, D_MSIP);
        step();                                   // edge 63
        chk("msip_ack_one", 64'(bus64.ack), 64'd0);
        set64(1'b0, 1'b0, 1'b0, 3'b010, 64'd0);

        // mtime write away from a tick
        set64(1'b1, 1'b1, 1'b1, 3'b010, 64'h100);
        step();                                   // edge 64: accept
        set64(1'b0, 1'b0, 1'b0, 3'b010, 64'd0);
        step();                                   // edge 65: ack
        chk("mt_notick_ack", 64'(bus64.ack), 64'd1);
        chk("mt_notick_val", mtime64, 64'h100);
        chk("mt_notick_rd", bus64.dat_i_p, 64'h100);
        step();

        // mtime write on the edge before a tick (accept 89, tick 90)
        while (edge_n < 88) step();
        set64(1'b1, 1'b1, 1'b1, 3'b010, 64'h100);
        step();                                   // edge 89
        set64(1'b0, 1'b0, 1'b0, 3'b010, 64'd0);
        step();                                   // edge 90: ack + tick
        chk("mt_pretick_ack", 64'(bus64.ack), 64'd1);
        chk("mt_pretick_val", mtime64, 64'h101);
        chk("mt_pretick_rd", bus64.dat_i_p, 64'h101);
        step();

        // mtime write on a tick edge drops the increment (edge 120)
        while (edge_n < 119) step();
        set64(1'b1, 1'b1, 1'b1, 3'b010, 64'h200);
        step();                                   // edge 120
        chk("mt_ontick_val", mtime64, 64'h200);
        set64(1'b0, 1'b0, 1'b0, 3'b010, 64'd0);
        step();                                   // edge 121: ack
        chk("mt_ontick_ack", 64'(bus64.ack), 64'd1);
        chk("mt_ontick_hold", mtime64, 64'h200);
        step();

        // Unmapped address: acked, no register change, reads 0
        set64(1'b1, 1'b1, 1'b1, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF);
        step();                                   // edge 123
        set64(1'b0, 1'b0, 1'b0, 3'b001, 64'd0);
        step();                                   // edge 124
        chk("unmap_ack", 64'(bus64.ack), 64'd1);
        chk("unmap_msip", msip64, D_MSIP);
        chk("unmap_mtime", mtime64, 64'h200);
        chk("unmap_cmp", cmp64, 64'd0);
        chk("unmap_rd", bus64.dat_i_p, 64'd0);
        step();                                   // edge 125

        // Held read request: one accept per three edges
        set64(1'b1, 1'b1, 1'b0, 3'b000, 64'd0);
        step();                                   // edge 126: accept
        step();                                   // edge 127: ack
        chk("b2b_ack1", 64'(bus64.ack), 64'd1);
        chk("b2b_rd", bus64.dat_i_p, D_MSIP);
        step();                                   // edge 128: blocked
        chk("b2b_gap", 64'(bus64.ack), 64'd0);
        step();                                   // edge 129: accept
        chk("b2b_acc2", 64'(bus64.ack), 64'd0);
        step();                                   // edge 130: ack
        chk("b2b_ack2", 64'(bus64.ack), 64'd1);
        set64(1'b0, 1'b0, 1'b0, 3'b000, 64'd0);
        step();                                   // edge 131

        // mtimecmp 64-bit write
        set64(1'b1, 1'b1, 1'b1, 3'b011, D_CMP);
        step();                                   // edge 132
        set64(1'b0, 1'b0, 1'b0, 3'b011, 64'd0);
        step();                                   // edge 133
        chk("cmp64_ack", 64'(bus64.ack), 64'd1);
        chk("cmp64_val", cmp64, D_CMP);
        chk("cmp64_rd", bus64.dat_i_p, D_CMP);
        step();                                   // edge 134

        // 32-bit mode: mtimecmp by halves
        set32(1'b1, 1'b1, 1'b1, 3'b111, 32'hAAAA5555);
        step();                                   // edge 135
        set32(1'b0, 1'b0, 1'b0, 3'b111, 32'd0);
        step();                                   // edge 136
        chk("cmp32_hi_ack", 64'(bus32.ack), 64'd1);
        chk("cmp32_hi_val", cmp32, 64'hAAAA5555_00000000);
        step();                                   // edge 137
        set32(1'b1, 1'b1, 1'b1, 3'b011, 32'h12345678);
        step();                                   // edge 138
        set32(1'b0, 1'b0, 1'b0, 3'b011, 32'd0);
        step();                                   // edge 139
        chk("cmp32_val", cmp32, 64'hAAAA5555_12345678);
        step();                                   // edge 140
        set32(1'b0, 1'b0, 1'b0, 3'b111, 32'd0);
        #1;
        chk("cmp32_rd_hi", 64'(bus32.dat_i_p), 64'hAAAA5555);
        set32(1'b0, 1'b0, 1'b0, 3'b011, 32'd0);
        #1;
        chk("cmp32_rd_lo", 64'(bus32.dat_i_p), 64'h12345678);

        // 32-bit mode: upper mtime write keeps the counted lower half (4 ticks by edge 141)
        set32(1'b1, 1'b1, 1'b1, 3'b110, 32'h1);
        step();                                   // edge 141
        chk("mt32_hi_val", mtime32, 64'h00000001_00000004);
        chk("mt32_hi_rd", 64'(bus32.dat_i_p), 64'h1);
        set32(1'b0, 1'b0, 1'b0, 3'b010, 32'd0);
        #1;
        chk("mt32_lo_rd", 64'(bus32.dat_i_p), 64'h4);
        step();                                   // edge 142
        chk("mt32_ack", 64'(bus32.ack), 64'd1);
        step();

        // 32-bit msip
        set32(1'b1, 1'b1, 1'b1, 3'b000, 32'hDEADBEEF);
        step();
        set32(1'b0, 1'b0, 1'b0, 3'b000, 32'd0);
        step();
        chk("msip32_ack", 64'(bus32.ack), 64'd1);
        chk("msip32_val", 64'(msip32), 64'hDEADBEEF);
        chk("msip32_rd", 64'(bus32.dat_i_p), 64'hDEADBEEF);
        step();

        // Reset mid-transfer: write applied, then cleared, no ack
        set64(1'b1, 1'b1, 1'b1, 3'b000, 64'h55);
        step();                                   // accept
        chk("abort_pre", msip64, 64'h55);
        set64(1'b0, 1'b0, 1'b0, 3'b000, 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort_msip", msip64, 64'd0);
        chk("abort_mtime", mtime64, 64'd0);
        chk("abort_cmp", cmp64, 64'd0);
        chk("abort_ack_now", 64'(bus64.ack), 64'd0);
        step();
        chk("abort_ack_edge", 64'(bus64.ack), 64'd0);
        reset = 1'b1;
        step();
        chk("abort_ack_after", 64'(bus64.ack), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
